// File: rtl/bnn_pkg.sv
// Shared definitions for the binary fully-connected layer engine:
// controller state encoding and a constant-foldable ceil(log2) helper.
package bnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REST,
        ST_FETCH,
        ST_DRAIN,
        ST_ACT,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational PAR-lane XNOR followed by a population count; counts the
// lanes where activation and weight bits agree.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int PAR   = 8,
    parameter int CNT_W = clog2(PAR + 1)
) (
    input  logic [PAR-1:0]   x_i,
    input  logic [PAR-1:0]   w_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [PAR-1:0] agree;

    always_comb begin
        agree = ~(x_i ^ w_i);
        cnt_o = '0;
        for (int i = 0; i < PAR; i++) begin
            cnt_o = cnt_o + CNT_W'(agree[i]);
        end
    end

endmodule

// File: rtl/bnn_layer_engine.sv
// One fully-connected binary layer: streams input/weight words, accumulates
// XNOR-popcounts per neuron, sign-activates and writes packed output words.
module bnn_layer_engine
    import bnn_pkg::*;
#(
    parameter int PAR         = 8,
    parameter int W_ADDR_LEN  = 20,
    parameter int X_ADDR_LEN  = 10,
    parameter int N_OUT_LEN   = 11,
    parameter int ACC_W       = 16,
    parameter int REST_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [X_ADDR_LEN-1:0] cfg_n_in_words,
    input  logic [N_OUT_LEN-1:0]  cfg_n_out,
    input  logic [X_ADDR_LEN-1:0] cfg_x_base,
    input  logic [X_ADDR_LEN-1:0] cfg_y_base,
    input  logic [W_ADDR_LEN-1:0] cfg_w_base,
    output logic                  busy,
    output logic                  done,
    output logic [W_ADDR_LEN-1:0] w_addr,
    output logic                  w_re,
    input  logic [PAR-1:0]        w_rdata,
    output logic [X_ADDR_LEN-1:0] x_addr,
    output logic                  x_re,
    input  logic [PAR-1:0]        x_rdata,
    output logic [X_ADDR_LEN-1:0] y_addr,
    output logic                  y_we,
    output logic [PAR-1:0]        y_wdata
);

    localparam int CNT_W  = clog2(PAR + 1);
    localparam int LANE_W = (clog2(PAR) > 0) ? clog2(PAR) : 1;
    localparam int THR_W  = ACC_W + 1;

    state_t                state_q;
    logic [X_ADDR_LEN-1:0] n_in_q, x_base_q, y_base_q, k_q;
    logic [N_OUT_LEN-1:0]  n_out_q, j_q, word_q;
    logic [W_ADDR_LEN-1:0] wptr_q;
    logic [LANE_W-1:0]     lane_q;
    logic [PAR-1:0]        pack_q;
    logic [ACC_W-1:0]      acc_q;
    logic [15:0]           rest_q;
    logic                  rd_vld_q;

    logic                  busy_q, done_q, w_re_q, x_re_q, y_we_q;
    logic [W_ADDR_LEN-1:0] w_addr_q;
    logic [X_ADDR_LEN-1:0] x_addr_q, y_addr_q;
    logic [PAR-1:0]        y_wdata_q;

    logic [CNT_W-1:0]      pop;
    logic [ACC_W-1:0]      acc_d;
    logic [THR_W-1:0]      thr;
    logic                  act_bit;
    logic [PAR-1:0]        pack_d;

    bnn_xnor_popcount #(
        .PAR   (PAR),
        .CNT_W (CNT_W)
    ) u_popcount (
        .x_i   (x_rdata),
        .w_i   (w_rdata),
        .cnt_o (pop)
    );

    // Doubling the sum instead of halving the threshold keeps odd-width ties exact.
    assign acc_d   = acc_q + ACC_W'(pop);
    assign thr     = THR_W'(n_in_q) * THR_W'(PAR);
    assign act_bit = ({acc_q, 1'b0} >= thr);

    always_comb begin
        pack_d         = pack_q;
        pack_d[lane_q] = act_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            n_in_q    <= '0;
            n_out_q   <= '0;
            x_base_q  <= '0;
            y_base_q  <= '0;
            wptr_q    <= '0;
            k_q       <= '0;
            j_q       <= '0;
            word_q    <= '0;
            lane_q    <= '0;
            pack_q    <= '0;
            acc_q     <= '0;
            rest_q    <= '0;
            rd_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_re_q    <= 1'b0;
            x_re_q    <= 1'b0;
            y_we_q    <= 1'b0;
            w_addr_q  <= '0;
            x_addr_q  <= '0;
            y_addr_q  <= '0;
            y_wdata_q <= '0;
        end else begin
            // Read data lands one cycle after its enable.
            rd_vld_q <= x_re_q;
            if (rd_vld_q) begin
                acc_q <= acc_d;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        n_in_q   <= cfg_n_in_words;
                        n_out_q  <= cfg_n_out;
                        x_base_q <= cfg_x_base;
                        y_base_q <= cfg_y_base;
                        wptr_q   <= cfg_w_base;
                        j_q      <= '0;
                        word_q   <= '0;
                        lane_q   <= '0;
                        pack_q   <= '0;
                        rest_q   <= '0;
                        busy_q   <= 1'b1;
                        if (cfg_n_in_words == '0 || cfg_n_out == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (REST_CYCLES == 0) begin
                            state_q  <= ST_FETCH;
                            k_q      <= '0;
                            x_re_q   <= 1'b1;
                            w_re_q   <= 1'b1;
                            x_addr_q <= cfg_x_base;
                            w_addr_q <= cfg_w_base;
                        end else begin
                            state_q <= ST_REST;
                        end
                    end
                end

                ST_REST: begin
                    if (rest_q == 16'(REST_CYCLES - 1)) begin
                        state_q  <= ST_FETCH;
                        k_q      <= '0;
                        x_re_q   <= 1'b1;
                        w_re_q   <= 1'b1;
                        x_addr_q <= x_base_q;
                        w_addr_q <= wptr_q;
                    end else begin
                        rest_q <= rest_q + 16'd1;
                    end
                end

                ST_FETCH: begin
                    if (k_q == '0) begin
                        acc_q <= '0;
                    end
                    if (k_q == n_in_q - X_ADDR_LEN'(1)) begin
                        state_q <= ST_DRAIN;
                        x_re_q  <= 1'b0;
                        w_re_q  <= 1'b0;
                        wptr_q  <= w_addr_q + W_ADDR_LEN'(1);
                    end else begin
                        k_q      <= k_q + X_ADDR_LEN'(1);
                        x_addr_q <= x_addr_q + X_ADDR_LEN'(1);
                        w_addr_q <= w_addr_q + W_ADDR_LEN'(1);
                    end
                end

                ST_DRAIN: begin
                    state_q <= ST_ACT;
                end

                ST_ACT: begin
                    if (lane_q == LANE_W'(PAR - 1) || j_q == n_out_q - N_OUT_LEN'(1)) begin
                        state_q   <= ST_WRITE;
                        y_we_q    <= 1'b1;
                        y_addr_q  <= y_base_q + X_ADDR_LEN'(word_q);
                        y_wdata_q <= pack_d;
                        pack_q    <= '0;
                    end else begin
                        pack_q   <= pack_d;
                        j_q      <= j_q + N_OUT_LEN'(1);
                        lane_q   <= lane_q + LANE_W'(1);
                        state_q  <= ST_FETCH;
                        k_q      <= '0;
                        x_re_q   <= 1'b1;
                        w_re_q   <= 1'b1;
                        x_addr_q <= x_base_q;
                        w_addr_q <= wptr_q;
                    end
                end

                ST_WRITE: begin
                    y_we_q <= 1'b0;
                    word_q <= word_q + N_OUT_LEN'(1);
                    lane_q <= '0;
                    if (j_q == n_out_q - N_OUT_LEN'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        j_q      <= j_q + N_OUT_LEN'(1);
                        state_q  <= ST_FETCH;
                        k_q      <= '0;
                        x_re_q   <= 1'b1;
                        w_re_q   <= 1'b1;
                        x_addr_q <= x_base_q;
                        w_addr_q <= wptr_q;
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign w_addr  = w_addr_q;
    assign w_re    = w_re_q;
    assign x_addr  = x_addr_q;
    assign x_re    = x_re_q;
    assign y_addr  = y_addr_q;
    assign y_we    = y_we_q;
    assign y_wdata = y_wdata_q;

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Scoreboard bench for bnn_layer_engine: two instances (no rest / 10 rest cycles)
// share behavioural memories; a loop-based reference model predicts reads, writes and timing.
module tb_bnn_layer_engine;

    localparam int PAR = 8;
    localparam int WA  = 20;
    localparam int XA  = 10;
    localparam int NO  = 11;

    typedef struct {
        int          inst;
        logic [XA-1:0] xa;
        logic [WA-1:0] wa;
    } rd_t;

    typedef struct {
        int          inst;
        logic [XA-1:0] ya;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start   [2];
    logic          busy    [2];
    logic          done    [2];
    logic          w_re    [2];
    logic          x_re    [2];
    logic          y_we    [2];
    logic [WA-1:0] w_addr  [2];
    logic [XA-1:0] x_addr  [2];
    logic [XA-1:0] y_addr  [2];
    logic [7:0]    w_rdata [2];
    logic [7:0]    x_rdata [2];
    logic [7:0]    y_wdata [2];

    logic [XA-1:0] cfg_n_in, cfg_xb, cfg_yb;
    logic [NO-1:0] cfg_n_out;
    logic [WA-1:0] cfg_wb;

    logic [7:0] xmem [1024];
    logic [7:0] wmem [4096];

    rd_t rd_q[$];
    wr_t wr_q[$];
    rd_t rd_e;
    wr_t wr_e;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int start_cyc   [2];
    int exp_lat     [2];
    int exp_first   [2];
    int first_re    [2];
    int reads_seen  [2];
    int done_seen   [2];
    int done_before [2];
    bit done_exp    [2];

    bnn_layer_engine #(.PAR(PAR), .W_ADDR_LEN(WA), .X_ADDR_LEN(XA), .N_OUT_LEN(NO),
                       .ACC_W(16), .REST_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .cfg_n_in_words(cfg_n_in), .cfg_n_out(cfg_n_out),
        .cfg_x_base(cfg_xb), .cfg_y_base(cfg_yb), .cfg_w_base(cfg_wb),
        .busy(busy[0]), .done(done[0]),
        .w_addr(w_addr[0]), .w_re(w_re[0]), .w_rdata(w_rdata[0]),
        .x_addr(x_addr[0]), .x_re(x_re[0]), .x_rdata(x_rdata[0]),
        .y_addr(y_addr[0]), .y_we(y_we[0]), .y_wdata(y_wdata[0])
    );

    bnn_layer_engine #(.PAR(PAR), .W_ADDR_LEN(WA), .X_ADDR_LEN(XA), .N_OUT_LEN(NO),
                       .ACC_W(16), .REST_CYCLES(10)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .cfg_n_in_words(cfg_n_in), .cfg_n_out(cfg_n_out),
        .cfg_x_base(cfg_xb), .cfg_y_base(cfg_yb), .cfg_w_base(cfg_wb),
        .busy(busy[1]), .done(done[1]),
        .w_addr(w_addr[1]), .w_re(w_re[1]), .w_rdata(w_rdata[1]),
        .x_addr(x_addr[1]), .x_re(x_re[1]), .x_rdata(x_rdata[1]),
        .y_addr(y_addr[1]), .y_we(y_we[1]), .y_wdata(y_wdata[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (x_re[i]) x_rdata[i] <= xmem[x_addr[i]];
            if (w_re[i]) w_rdata[i] <= wmem[w_addr[i][11:0]];
        end
    end

    function automatic void chk(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int popc(input logic [7:0] v);
        int n = 0;
        for (int b = 0; b < 8; b++) n += int'(v[b]);
        return n;
    endfunction

    function automatic int rest_of(input int i);
        return (i == 0) ? 0 : 10;
    endfunction

    // Monitor: every DUT memory access, write and done pulse is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (x_re[i] || w_re[i]) begin
                    chk(x_re[i] === w_re[i], "re_pair", 32'(w_re[i]), 32'(x_re[i]));
                    if (first_re[i] < 0) first_re[i] = cyc - start_cyc[i];
                    reads_seen[i]++;
                    chk(rd_q.size() != 0, "read_unexpected", 32'(i), 32'(x_addr[i]));
                    if (rd_q.size() != 0) begin
                        rd_e = rd_q.pop_front();
                        chk(rd_e.inst == i, "read_inst", 32'(i), 32'(rd_e.inst));
                        chk(x_addr[i] === rd_e.xa, "x_addr", 32'(x_addr[i]), 32'(rd_e.xa));
                        chk(w_addr[i] === rd_e.wa, "w_addr", 32'(w_addr[i]), 32'(rd_e.wa));
                    end
                end
                if (y_we[i]) begin
                    chk(wr_q.size() != 0, "write_unexpected", 32'(i), 32'(y_addr[i]));
                    if (wr_q.size() != 0) begin
                        wr_e = wr_q.pop_front();
                        chk(wr_e.inst == i, "write_inst", 32'(i), 32'(wr_e.inst));
                        chk(y_addr[i] === wr_e.ya, "y_addr", 32'(y_addr[i]), 32'(wr_e.ya));
                        chk(y_wdata[i] === wr_e.d, "y_wdata", 32'(y_wdata[i]), 32'(wr_e.d));
                    end
                end
                if (done[i]) begin
                    chk(done_exp[i], "done_unexpected", 32'(i), 32'(0));
                    chk(cyc - start_cyc[i] == exp_lat[i], "done_latency",
                        32'(cyc - start_cyc[i]), 32'(exp_lat[i]));
                    chk(busy[i] === 1'b1, "busy_at_done", 32'(busy[i]), 32'(1));
                    done_exp[i] = 1'b0;
                    done_seen[i]++;
                end
            end
        end
    end

    task automatic fill(input int xb, input int n_in, input int wb, input int n_w);
        for (int k = 0; k < n_in; k++) xmem[(xb + k) % 1024] = 8'($urandom);
        for (int k = 0; k < n_w; k++)  wmem[(wb + k) % 4096] = 8'($urandom);
    endtask

    task automatic launch(input int i, input int n_in, input int n_out,
                          input int xb, input int yb, input int wb);
        logic [7:0] word;
        int acc;
        rd_t r;
        wr_t w;
        word = 8'h00;
        for (int j = 0; j < n_out && n_in > 0; j++) begin
            acc = 0;
            for (int k = 0; k < n_in; k++) begin
                r.inst = i;
                r.xa = XA'(xb + k);
                r.wa = WA'(wb + j * n_in + k);
                rd_q.push_back(r);
                acc += popc(~(xmem[(xb + k) % 1024] ^ wmem[(wb + j * n_in + k) % 4096]));
            end
            word[j % PAR] = (2 * acc >= n_in * PAR);
            if (j % PAR == PAR - 1 || j == n_out - 1) begin
                w.inst = i;
                w.ya = XA'(yb + j / PAR);
                w.d = word;
                wr_q.push_back(w);
                word = 8'h00;
            end
        end
        if (n_in == 0 || n_out == 0) begin
            exp_lat[i] = 1;
            exp_first[i] = -1;
        end else begin
            exp_lat[i] = rest_of(i) + n_out * (n_in + 2) + (n_out + PAR - 1) / PAR + 1;
            exp_first[i] = rest_of(i) + 1;
        end
        @(negedge clk); #1;
        cfg_n_in = XA'(n_in);
        cfg_n_out = NO'(n_out);
        cfg_xb = XA'(xb);
        cfg_yb = XA'(yb);
        cfg_wb = WA'(wb);
        start_cyc[i] = cyc;
        first_re[i] = -1;
        reads_seen[i] = 0;
        done_before[i] = done_seen[i];
        done_exp[i] = 1'b1;
        start[i] = 1'b1;
        @(negedge clk); #1;
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (done_seen[i] == done_before[i] && n < exp_lat[i] + 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk(done_seen[i] != done_before[i], "done_timeout", 32'(n), 32'(exp_lat[i]));
        chk(first_re[i] == exp_first[i], "first_read_cycle", 32'(first_re[i]), 32'(exp_first[i]));
        @(negedge clk); #1;
        chk(busy[i] === 1'b0, "busy_after_done", 32'(busy[i]), 32'(0));
        chk(rd_q.size() == 0 && wr_q.size() == 0, "queues_drained",
            32'(rd_q.size()), 32'(wr_q.size()));
    endtask

    task automatic run(input int i, input int n_in, input int n_out,
                       input int xb, input int yb, input int wb);
        fill(xb, n_in, wb, n_in * n_out);
        launch(i, n_in, n_out, xb, yb, wb);
        wait_done(i);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            done_seen[i] = 0;
            done_exp[i] = 1'b0;
            first_re[i] = -1;
            reads_seen[i] = 0;
            start_cyc[i] = 0;
        end
        cfg_n_in = '0; cfg_n_out = '0; cfg_xb = '0; cfg_yb = '0; cfg_wb = '0;
        for (int a = 0; a < 1024; a++) xmem[a] = 8'h00;
        for (int a = 0; a < 4096; a++) wmem[a] = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk({busy[i], done[i], w_re[i], x_re[i], y_we[i], w_addr[i], x_addr[i],
                 y_addr[i], y_wdata[i]} === '0, "reset_outputs", 32'(i), 32'(0));
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed single-neuron cases: full agreement, full disagreement, exact tie.
        xmem[5] = 8'hFF; wmem[100] = 8'hFF;
        launch(0, 1, 1, 5, 40, 100);
        wait_done(0);
        xmem[5] = 8'hFF; wmem[100] = 8'h00;
        launch(0, 1, 1, 5, 41, 100);
        wait_done(0);
        xmem[5] = 8'h0F; wmem[100] = 8'hFF;
        launch(0, 1, 1, 5, 42, 100);
        wait_done(0);

        // Two output words, the second partial.
        run(0, 3, 10, 200, 300, 1000);

        // Rest delay and a start while busy.
        fill(17, 2, 2000, 6);
        launch(1, 2, 3, 17, 60, 2000);
        repeat (2) @(negedge clk);
        #1;
        cfg_n_in = XA'(5); cfg_n_out = NO'(7); cfg_xb = XA'(500); cfg_wb = WA'(3000);
        start[1] = 1'b1;
        @(negedge clk); #1;
        start[1] = 1'b0;
        wait_done(1);
        repeat (20) @(negedge clk);
        #1;
        chk(done_seen[1] == done_before[1] + 1, "single_done", 32'(done_seen[1]),
            32'(done_before[1] + 1));

        // Empty layers, then a normal layer on the same instance.
        launch(0, 4, 0, 10, 10, 10);
        wait_done(0);
        run(0, 2, 5, 30, 70, 400);
        launch(1, 0, 9, 10, 10, 10);
        wait_done(1);

        // Abort mid-FETCH of neuron 5, then rerun the same layer.
        fill(600, 3, 2500, 24);
        launch(0, 3, 8, 600, 90, 2500);
        n = 0;
        while (reads_seen[0] < 16 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk(reads_seen[0] >= 16, "abort_point_reached", 32'(reads_seen[0]), 32'(16));
        rst = 1'b1;
        rd_q.delete();
        wr_q.delete();
        done_exp[0] = 1'b0;
        @(posedge clk); #1;
        chk({busy[0], done[0], w_re[0], x_re[0], y_we[0], w_addr[0], x_addr[0],
             y_addr[0], y_wdata[0]} === '0, "abort_outputs", 32'(x_re[0]), 32'(0));
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk(busy[0] === 1'b0 && done[0] === 1'b0, "idle_after_abort", 32'(busy[0]), 32'(0));
        launch(0, 3, 8, 600, 90, 2500);
        wait_done(0);

        // Randomised layers on both instances.
        for (int t = 0; t < 8; t++) begin
            run(t % 2, int'($urandom_range(1, 6)), int'($urandom_range(1, 20)),
                int'($urandom_range(0, 900)), int'($urandom_range(0, 900)),
                int'($urandom_range(0, 3000)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bnn_layer_engine.md
Name: bnn_layer_engine

Overview:
- Parametrised successor to the single-layer compute controller; runs one fully-connected binary layer.
- Per output neuron: streams packed input/weight words from memory, XNOR-popcount accumulates, sign-activates, packs output bits.
- Writes output bits back to activation memory. Cascading layers only needs new cfg_* values per start (ping-pong x/y bases).
- Sits between the top-level testbench/control and the weight, input and output SRAMs.

Parameters:
PAR, 8, bits per memory word (XNOR lanes per cycle)
W_ADDR_LEN, 20, weight address width
X_ADDR_LEN, 10, activation address width (input and output memory)
N_OUT_LEN, 11, width of neuron count
ACC_W, 16, accumulator width; must satisfy 2^ACC_W > max n_in_words*PAR
REST_CYCLES, 10, idle settle cycles after start before first fetch (0 allowed)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
cfg_n_in_words  in  X_ADDR_LEN  input words per neuron; latched at start
cfg_n_out  in  N_OUT_LEN  neurons in this layer; latched at start
cfg_x_base  in  X_ADDR_LEN  input activation base address
cfg_y_base  in  X_ADDR_LEN  output activation base address
cfg_w_base  in  W_ADDR_LEN  weight base address
busy  out  1  high from accepted start to done inclusive
done  out  1  one-cycle pulse at layer completion
w_addr  out  W_ADDR_LEN  weight read address
w_re  out  1  weight read enable
w_rdata  in  PAR  weight word; valid the cycle after w_re
x_addr  out  X_ADDR_LEN  input read address
x_re  out  1  input read enable
x_rdata  in  PAR  input word; valid the cycle after x_re
y_addr  out  X_ADDR_LEN  output write address
y_we  out  1  output write strobe
y_wdata  out  PAR  packed output bits; bit i = neuron (word*PAR+i)

Behaviour:
- Reset: state IDLE; all outputs 0 (busy, done, w_re, x_re, y_we, all addresses, y_wdata); counters and accumulator 0. Reset mid-layer aborts immediately with no write and no done.
- IDLE: on start=1, latch cfg_*; busy<=1; go to REST. Start while busy is ignored.
- Zero config: if latched n_in_words=0 or n_out=0, go straight to DONE. No memory access occurs.
- REST: count REST_CYCLES cycles, then go to FETCH with k=0, j=0.
- FETCH: each cycle x_re=w_re=1, x_addr=x_base+k, w_addr=w_base+j*n_in_words+k. Keep w_addr as a running pointer, no multiplier.
- FETCH (cont.): data returned at cycle t+1 is accumulated: acc += popcount(~(x_rdata^w_rdata)). acc clears at the first issue of each neuron. After issuing k=n_in_words-1, go to DRAIN.
- DRAIN: one cycle, no reads; accumulate the final word.
- ACT: bit = (2*acc >= n_in_words*PAR) — ties give 1. Shift bit into the packer at lane j mod PAR.
- ACT exit: if lane==PAR-1 or j==n_out-1, go to WRITE; otherwise j++ and FETCH.
- WRITE: y_we=1 for one cycle; y_addr=y_base+j/PAR; unused upper lanes of a final partial word are 0. Packer clears.
- WRITE exit: if j==n_out-1, go to DONE; else j++ and FETCH.
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
- Latency per neuron: n_in_words+2 cycles, plus 1 on a write cycle. Layer total = REST_CYCLES + n_out*(n_in_words+2) + ceil(n_out/PAR) + 1 after start.
- Read enables are 0 outside FETCH. Address outputs hold their last value when not enabled.
- Widths: popcount result is clog2(PAR+1) bits, zero-extended into acc. Threshold is compared at ACC_W+1 bits. Address adds wrap modulo 2^width with no error flag.

Decomposition:
- Shared package bnn_pkg: state encoding (IDLE, REST, FETCH, DRAIN, ACT, WRITE, DONE) and a clog2 function for the popcount width.
- One sub-module: bnn_xnor_popcount (combinational PAR-bit XNOR + popcount, parameter PAR). The FSM, counters, accumulator and packer stay in bnn_layer_engine.

Test Plan:
- PAR=8, REST_CYCLES=0, n_in=1, n_out=1, x=0xFF, w=0xFF -> acc=8, bit=1; one write y_wdata=0x01 at y_base; done at cycle 5 after start.
- n_in=1, n_out=1, x=0xFF, w=0x00 -> acc=0, y_wdata=0x00. Tie x=0x0F, w=0xFF -> acc=4, 8>=8, y_wdata=0x01.
- n_in=3, n_out=10, random x/w vs. golden model -> two writes (8 bits, then 2 bits with lanes 7:2 = 0); w_addr runs contiguously w_base..w_base+29.
- REST_CYCLES=10; start pulsed again while busy -> first x_re exactly 11 cycles after start; second start has no effect; exactly one done.
- cfg_n_out=0 -> no x_re/w_re/y_we; done pulses; then a normal start works.
- Assert rst mid-FETCH of neuron 5 -> all outputs 0 next edge, no y_we or done; a subsequent start reproduces correct results.
